// File: rtl/ag32gbd_ram_loader.sv
// ag32gbd_ram_loader: copies a byte stream into cartridge SRAM bank 0 through the mapper override inputs.
// Define AG32GBD_LOADER_CHECKSUM_EN to enable the running 16-bit byte checksum.
module ag32gbd_ram_loader #(
    parameter int WE_PULSE_CYCLES = 3,
    parameter int SETUP_CYCLES    = 1,
    parameter int HOLD_CYCLES     = 1
) (
    input  logic        sys_clock,
    input  logic        sys_resetn,
    input  logic        start,
    input  logic [12:0] byte_count,
    input  logic        abort,
    input  logic        Cart_nCS,
    input  logic        Cart_nRD,
    input  logic        Cart_nWR,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        is_gbd_writing_ram,
    output logic [7:0]  out_Writing_dq,
    output logic [11:0] out_Writing_Addr_low,
    output logic        out_Writing_nCS,
    output logic        out_Writing_nWE,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] checksum
);
    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] PULSE_LAST = 4'(WE_PULSE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_BUS, GRANT, WAIT_DATA, SETUP, PULSE, HOLD, RELEASE
    } state_t;

    state_t      state, state_n;
    logic        idle_seen, idle_seen_n;
    logic [3:0]  phase, phase_n;
    logic [12:0] remaining, remaining_n;
    logic [11:0] addr_n;
    logic [7:0]  dq_n;
    logic        aborted_n;
    logic        bus_idle, handshake;

    assign bus_idle  = Cart_nCS && Cart_nRD && Cart_nWR;
    assign handshake = (state == WAIT_DATA) && in_valid && in_ready;

    always_ff @(posedge sys_clock) begin
        if (!sys_resetn) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n     = state;
        idle_seen_n = idle_seen;
        phase_n     = phase;
        remaining_n = remaining;
        addr_n      = out_Writing_Addr_low;
        dq_n        = out_Writing_dq;
        aborted_n   = aborted;
        case (state)
            IDLE: if (start) begin
                state_n     = WAIT_BUS;
                remaining_n = (byte_count == 13'd0) ? 13'h1000 : byte_count;
                addr_n      = '0;
                aborted_n   = 1'b0;
                idle_seen_n = 1'b0;
            end
            WAIT_BUS: if (abort) begin
                state_n   = IDLE;
                aborted_n = 1'b1;
            end else begin
                idle_seen_n = bus_idle;
                if (bus_idle && idle_seen) state_n = GRANT;
            end
            GRANT: begin
                state_n   = abort ? RELEASE : WAIT_DATA;
                aborted_n = aborted || abort;
            end
            // A byte already handshaken is owed a write, so it wins over abort.
            WAIT_DATA: if (handshake) begin
                dq_n    = in_data;
                phase_n = '0;
                state_n = SETUP;
            end else if (abort) begin
                state_n   = RELEASE;
                aborted_n = 1'b1;
            end
            SETUP: begin
                phase_n = (phase == SETUP_LAST) ? 4'd0 : phase + 4'd1;
                state_n = (phase == SETUP_LAST) ? PULSE : SETUP;
            end
            PULSE: begin
                phase_n = (phase == PULSE_LAST) ? 4'd0 : phase + 4'd1;
                state_n = (phase == PULSE_LAST) ? HOLD : PULSE;
            end
            HOLD: if (phase == HOLD_LAST) begin
                phase_n     = '0;
                remaining_n = remaining - 13'd1;
                addr_n      = out_Writing_Addr_low + 12'd1;
                state_n     = (remaining == 13'd1 || abort) ? RELEASE : WAIT_DATA;
                aborted_n   = aborted || (abort && remaining != 13'd1);
            end else begin
                phase_n = phase + 4'd1;
            end
            RELEASE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state does.
    always_ff @(posedge sys_clock) begin
        if (!sys_resetn) begin
            idle_seen            <= 1'b0;
            phase                <= '0;
            remaining            <= '0;
            out_Writing_Addr_low <= '0;
            out_Writing_dq       <= '0;
            aborted              <= 1'b0;
            busy                 <= 1'b0;
            is_gbd_writing_ram   <= 1'b0;
            out_Writing_nCS      <= 1'b1;
            out_Writing_nWE      <= 1'b1;
            in_ready             <= 1'b0;
            done                 <= 1'b0;
        end else begin
            idle_seen            <= idle_seen_n;
            phase                <= phase_n;
            remaining            <= remaining_n;
            out_Writing_Addr_low <= addr_n;
            out_Writing_dq       <= dq_n;
            aborted              <= aborted_n;
            busy                 <= state_n != IDLE;
            is_gbd_writing_ram   <= state_n != IDLE && state_n != WAIT_BUS;
            out_Writing_nCS      <= !(state_n inside {SETUP, PULSE, HOLD});
            out_Writing_nWE      <= state_n != PULSE;
            in_ready             <= state_n == WAIT_DATA;
            done                 <= state == RELEASE;
        end
    end

`ifdef AG32GBD_LOADER_CHECKSUM_EN
    logic [15:0] sum;
    always_ff @(posedge sys_clock) begin
        if (!sys_resetn) sum <= '0;
        else if (state == IDLE && start) sum <= '0;
        else if (handshake) sum <= sum + {8'h00, in_data};
    end
    assign checksum = sum;
`else
    assign checksum = '0;
`endif
endmodule

// File: doc/ag32gbd_ram_loader.md
# ag32gbd_ram_loader

Bulk writer that copies a byte stream into cartridge SRAM bank 0 (offsets 0x000–0xFFF), upstream of the cartridge RAM mapper. It waits for the Game Boy cartridge bus to go idle, takes over the SRAM through the mapper's override inputs, and issues one setup/strobe/hold write cycle per byte. After the last byte it releases the SRAM back to the cartridge path. Typical use: preloading a 4 KiB camera save/settings block.

## Interface
- `WE_PULSE_CYCLES`, default 3: sys_clock cycles `out_Writing_nWE` is held low per byte (1–15).
- `SETUP_CYCLES`, default 1: cycles with address/data/nCS valid before nWE falls (1–7).
- `HOLD_CYCLES`, default 1: cycles address/data/nCS stay valid after nWE rises (1–7).
- `sys_clock` in 1: sole clock.
- `sys_resetn` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request to begin a transfer; honoured only in IDLE.
- `byte_count` in 13: bytes to write (1–4096), sampled with `start`; 0 is treated as 4096.
- `abort` in 1: level request to stop early.
- `Cart_nCS` in 1: cartridge chip select; high means idle.
- `Cart_nRD` in 1: cartridge read strobe; high means idle.
- `Cart_nWR` in 1: cartridge write strobe; high means idle.
- `in_valid` in 1: source byte valid.
- `in_data` in 8: source byte.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `is_gbd_writing_ram` out 1: SRAM override select for the mapper.
- `out_Writing_dq` out 8: SRAM write data.
- `out_Writing_Addr_low` out 12: SRAM offset.
- `out_Writing_nCS` out 1: SRAM chip select, active-low.
- `out_Writing_nWE` out 1: SRAM write enable, active-low.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at completion.
- `aborted` out 1: sticky flag set when a transfer ends early; cleared by the next `start`.
- `checksum` out 16: running sum of the bytes written (see Configuration).

## Operation
- States: IDLE, WAIT_BUS, GRANT, WAIT_DATA, SETUP, PULSE, HOLD, RELEASE.
- IDLE → WAIT_BUS on `start`.
  - Latch `byte_count`.
  - Clear the address counter, `aborted` and `checksum`.
- WAIT_BUS:
  - Count consecutive cycles with `Cart_nCS && Cart_nRD && Cart_nWR` all high.
  - Any low input resets the count.
  - Move to GRANT after 2 consecutive idle cycles.
- GRANT: raise `is_gbd_writing_ram` with nCS and nWE both high for 1 cycle, then go to WAIT_DATA.
- WAIT_DATA:
  - `in_ready`=1.
  - On handshake: register `in_data` into `out_Writing_dq`, then go to SETUP.
- SETUP: nCS=0, nWE=1 for `SETUP_CYCLES`, then PULSE.
- PULSE: nCS=0, nWE=0 for `WE_PULSE_CYCLES`, then HOLD.
- HOLD:
  - nCS=0, nWE=1 for `HOLD_CYCLES`.
  - Then decrement the remaining count and increment the address.
  - Go to RELEASE if the remaining count reaches 0 or `abort` is high; otherwise go to WAIT_DATA.
- RELEASE:
  - nCS=1, nWE=1 with `is_gbd_writing_ram` still 1 for 1 cycle.
  - Then go to IDLE, pulse `done`, and drop `is_gbd_writing_ram` on the same edge.
- `abort` handling by state:
  - WAIT_BUS, GRANT or WAIT_DATA: go directly to RELEASE (or straight to IDLE from WAIT_BUS, since the SRAM was never taken) and set `aborted`.
  - SETUP, PULSE or HOLD: the current byte always completes, so no truncated write strobe is ever produced; `aborted` is set at HOLD exit.
- Address is 12 bits. After byte 4096 it wraps to 0x000, but the count terminates the transfer first.
- `start` while not in IDLE is ignored.
- Cartridge activity after GRANT is ignored (the loader owns the SRAM).

## Timing
- Reset values:
  - State IDLE.
  - `is_gbd_writing_ram`=0, `out_Writing_nCS`=1, `out_Writing_nWE`=1.
  - `out_Writing_dq`=0x00, `out_Writing_Addr_low`=0x000.
  - `in_ready`=0, `busy`=0, `done`=0, `aborted`=0, `checksum`=0.
- All outputs are registered.
- `is_gbd_writing_ram` is 1 for at least 1 cycle before the first nCS falls and for 1 cycle after the last nCS rises.
- Address and data are stable for the full nCS-low window.
- Minimum cycles per byte with a source that is always valid: 1 + SETUP + PULSE + HOLD (6 at defaults).
- Minimum `start`-to-first-nWE-fall latency with an idle bus: 1 (IDLE→WAIT_BUS) + 2 (idle qualification) + 1 (GRANT) + 1 (WAIT_DATA) + SETUP cycles.
- Synchronous reset mid-transfer returns every output to its reset value on the next edge. A partial nWE pulse is acceptable only under reset.

## Configuration
- `AG32GBD_LOADER_CHECKSUM_EN` defined:
  - `checksum` accumulates a 16-bit wrapping sum of each byte at handshake.
  - It is cleared on `start` and holds its value after `done`.
- Macro undefined: `checksum` is tied to 0 and no adder is generated.

## Test plan
- Idle bus, `byte_count`=4, bytes 0x11,0x22,0x33,0x44 always valid, defaults → writes to offsets 0x000–0x003 with those data; each nWE-low window is 3 cycles; `done` pulses once; `checksum`=0x00AA when enabled.
- `Cart_nCS` low for 5 cycles after `start` → no nCS fall and `is_gbd_writing_ram` stays 0 until 2 idle cycles after `Cart_nCS` rises.
- `in_valid` gaps of 3 cycles between bytes → nCS stays high during gaps; `out_Writing_Addr_low` advances by exactly 1 per byte.
- `abort` asserted in the 2nd PULSE cycle of byte 2 → byte 2 completes with a full 3-cycle nWE; then RELEASE; `aborted`=1; `done` pulses.
- `byte_count`=0 → 4096 writes; last offset 0xFFF; `out_Writing_Addr_low` ends at 0x000.
- `sys_resetn` low during PULSE → next edge: nCS=1, nWE=1, `is_gbd_writing_ram`=0, state IDLE.
